// File: rtl/air_conditioning_ctrl.sv
// air_conditioning_ctrl
//   Step controller for room temperature. On every clock it compares the
//   measured temperature with the setpoint. It then registers a command that
//   is one STEP closer to the setpoint, and it never overshoots the setpoint.
//   When the command is fed back as temp, the room converges on ideal.
//
// Parameters:
//   WIDTH    - width of temp / ideal / out_temp (unsigned)
//   STEP     - temperature change per clock (1..2^WIDTH-1)
//   DEADBAND - no correction while |temp - ideal| <= DEADBAND
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   temp     - measured temperature
//   ideal    - target setpoint
//   out_temp - registered next temperature command
//   heating  - registered: last update raised the temperature
//   cooling  - registered: last update lowered the temperature
//   settled  - registered: last update found temp inside the deadband
module air_conditioning_ctrl #(
  parameter int WIDTH    = 6,
  parameter int STEP     = 1,
  parameter int DEADBAND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] temp,
  input  logic [WIDTH-1:0] ideal,
  output logic [WIDTH-1:0] out_temp,
  output logic             heating,
  output logic             cooling,
  output logic             settled
);

  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   DBAND_W = (WIDTH+1)'(DEADBAND);

  logic [WIDTH-1:0] out_temp_d, out_temp_q;
  logic             heating_d, heating_q;
  logic             cooling_d, cooling_q;
  logic             settled_d, settled_q;
  logic [WIDTH:0]   diff;

  always_comb begin
    out_temp_d = temp;
    heating_d  = 1'b0;
    cooling_d  = 1'b0;
    settled_d  = 1'b0;

    // The extra bit makes the subtraction unable to wrap.
    if (temp >= ideal) diff = {1'b0, temp} - {1'b0, ideal};
    else               diff = {1'b0, ideal} - {1'b0, temp};

    if (diff <= DBAND_W) begin
      settled_d = 1'b1;
    end else if (temp < ideal) begin
      heating_d = 1'b1;
      // The step is taken only while it stays short of ideal. This means the
      // sum stays at or below ideal and cannot overflow.
      out_temp_d = (diff > STEP_W) ? temp + STEP_N : ideal;
    end else begin
      cooling_d = 1'b1;
      out_temp_d = (diff > STEP_W) ? temp - STEP_N : ideal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_temp_q <= '0;
      heating_q  <= 1'b0;
      cooling_q  <= 1'b0;
      settled_q  <= 1'b0;
    end else begin
      out_temp_q <= out_temp_d;
      heating_q  <= heating_d;
      cooling_q  <= cooling_d;
      settled_q  <= settled_d;
    end
  end

  assign out_temp = out_temp_q;
  assign heating  = heating_q;
  assign cooling  = cooling_q;
  assign settled  = settled_q;

endmodule

// File: tb/tb_air_conditioning_ctrl.sv
// Directed testbench for air_conditioning_ctrl. It uses three instances:
// the default configuration, STEP=4, and DEADBAND=1.
// Each observed value is packed as {out_temp, heating, cooling, settled}.
module tb_air_conditioning_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] temp;
  logic [5:0] ideal;

  logic [5:0] o0, o1, o2;
  logic       h0, h1, h2, c0, c1, c2, s0, s1, s2;
  logic [8:0] obs0, obs1, obs2;

  int n_checks = 0;
  int n_fail   = 0;

  air_conditioning_ctrl #(.WIDTH(6), .STEP(1), .DEADBAND(0)) u_def (
    .clk(clk), .rst_n(rst_n), .temp(temp), .ideal(ideal),
    .out_temp(o0), .heating(h0), .cooling(c0), .settled(s0)
  );

  air_conditioning_ctrl #(.WIDTH(6), .STEP(4), .DEADBAND(0)) u_step4 (
    .clk(clk), .rst_n(rst_n), .temp(temp), .ideal(ideal),
    .out_temp(o1), .heating(h1), .cooling(c1), .settled(s1)
  );

  air_conditioning_ctrl #(.WIDTH(6), .STEP(1), .DEADBAND(1)) u_db1 (
    .clk(clk), .rst_n(rst_n), .temp(temp), .ideal(ideal),
    .out_temp(o2), .heating(h2), .cooling(c2), .settled(s2)
  );

  assign obs0 = {o0, h0, c0, s0};
  assign obs1 = {o1, h1, c1, s1};
  assign obs2 = {o2, h2, c2, s2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, and settle 1ns past it for sampling.
  task automatic tick(input logic [5:0] t, input logic [5:0] i);
    temp  = t;
    ideal = i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    temp  = 6'd17;
    ideal = 6'd27;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({obs0, obs1, obs2} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h %h %h, want 000 000 000", obs0, obs1, obs2);
    end
    rst_n = 1'b1;
    tick(6'd17, 6'd27);
    n_checks++;
    if (obs0 !== {6'd18, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_first_update: got %h, want %h", obs0, {6'd18, 3'b100});
    end
    // Assert reset between edges. The outputs must clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs0, obs1, obs2} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h %h %h, want 000 000 000", obs0, obs1, obs2);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_heat_loop();
    logic [5:0] t;
    t = 6'd17;
    for (int k = 1; k <= 10; k++) begin
      tick(t, 6'd27);
      n_checks++;
      if (obs0 !== {6'(17 + k), 3'b100}) begin
        n_fail++;
        $display("FAIL heat_edge%0d: got %h, want %h", k, obs0, {6'(17 + k), 3'b100});
      end
      t = o0;
    end
    tick(t, 6'd27);
    n_checks++;
    if (obs0 !== {6'd27, 3'b001}) begin
      n_fail++;
      $display("FAIL heat_settle: got %h, want %h", obs0, {6'd27, 3'b001});
    end
  endtask

  task automatic test_cool_loop();
    logic [5:0] t;
    t = 6'd25;
    for (int k = 1; k <= 5; k++) begin
      tick(t, 6'd20);
      n_checks++;
      if (obs0 !== {6'(25 - k), 3'b010}) begin
        n_fail++;
        $display("FAIL cool_edge%0d: got %h, want %h", k, obs0, {6'(25 - k), 3'b010});
      end
      t = o0;
    end
    for (int k = 0; k < 2; k++) begin
      tick(t, 6'd20);
      n_checks++;
      if (obs0 !== {6'd20, 3'b001}) begin
        n_fail++;
        $display("FAIL cool_hold%0d: got %h, want %h", k, obs0, {6'd20, 3'b001});
      end
      t = o0;
    end
  endtask

  task automatic test_no_overshoot();
    tick(6'd25, 6'd27);
    n_checks++;
    if (obs1 !== {6'd27, 3'b100}) begin
      n_fail++;
      $display("FAIL step4_up_clamp: got %h, want %h", obs1, {6'd27, 3'b100});
    end
    tick(6'd31, 6'd29);
    n_checks++;
    if (obs1 !== {6'd29, 3'b010}) begin
      n_fail++;
      $display("FAIL step4_down_clamp: got %h, want %h", obs1, {6'd29, 3'b010});
    end
    tick(6'd17, 6'd27);
    n_checks++;
    if (obs1 !== {6'd21, 3'b100}) begin
      n_fail++;
      $display("FAIL step4_full_step: got %h, want %h", obs1, {6'd21, 3'b100});
    end
    // diff == STEP exactly lands on ideal.
    tick(6'd33, 6'd29);
    n_checks++;
    if (obs1 !== {6'd29, 3'b010}) begin
      n_fail++;
      $display("FAIL step4_equal_step: got %h, want %h", obs1, {6'd29, 3'b010});
    end
  endtask

  task automatic test_deadband();
    tick(6'd28, 6'd27);
    n_checks++;
    if (obs2 !== {6'd28, 3'b001}) begin
      n_fail++;
      $display("FAIL db_inside_hi: got %h, want %h", obs2, {6'd28, 3'b001});
    end
    tick(6'd29, 6'd27);
    n_checks++;
    if (obs2 !== {6'd28, 3'b010}) begin
      n_fail++;
      $display("FAIL db_outside_hi: got %h, want %h", obs2, {6'd28, 3'b010});
    end
    tick(6'd26, 6'd27);
    n_checks++;
    if (obs2 !== {6'd26, 3'b001}) begin
      n_fail++;
      $display("FAIL db_inside_lo: got %h, want %h", obs2, {6'd26, 3'b001});
    end
    tick(6'd25, 6'd27);
    n_checks++;
    if (obs2 !== {6'd26, 3'b100}) begin
      n_fail++;
      $display("FAIL db_outside_lo: got %h, want %h", obs2, {6'd26, 3'b100});
    end
  endtask

  task automatic test_extremes();
    tick(6'd63, 6'd0);
    n_checks++;
    if (obs0 !== {6'd62, 3'b010}) begin
      n_fail++;
      $display("FAIL extreme_top: got %h, want %h", obs0, {6'd62, 3'b010});
    end
    tick(6'd0, 6'd63);
    n_checks++;
    if (obs0 !== {6'd1, 3'b100}) begin
      n_fail++;
      $display("FAIL extreme_bottom: got %h, want %h", obs0, {6'd1, 3'b100});
    end
    tick(6'd63, 6'd63);
    n_checks++;
    if (obs0 !== {6'd63, 3'b001}) begin
      n_fail++;
      $display("FAIL extreme_equal: got %h, want %h", obs0, {6'd63, 3'b001});
    end
  endtask

  task automatic test_back_to_back();
    tick(6'd30, 6'd40);
    n_checks++;
    if (obs0 !== {6'd31, 3'b100}) begin
      n_fail++;
      $display("FAIL reverse_before: got %h, want %h", obs0, {6'd31, 3'b100});
    end
    tick(6'd30, 6'd10);
    n_checks++;
    if (obs0 !== {6'd29, 3'b010}) begin
      n_fail++;
      $display("FAIL reverse_after: got %h, want %h", obs0, {6'd29, 3'b010});
    end
    // Open loop: with temp held, the command repeats the single-step value.
    for (int k = 0; k < 3; k++) begin
      tick(6'd10, 6'd20);
      n_checks++;
      if (obs0 !== {6'd11, 3'b100}) begin
        n_fail++;
        $display("FAIL open_loop%0d: got %h, want %h", k, obs0, {6'd11, 3'b100});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    temp  = '0;
    ideal = '0;
    test_reset();
    test_heat_loop();
    test_cool_loop();
    test_no_overshoot();
    test_deadband();
    test_extremes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/air_conditioning_ctrl.md
Name: air_conditioning_ctrl

Overview:
- Room air-conditioning step controller in the smart-room temperature path.
- Each clock it compares the measured room temperature with the ideal setpoint and registers a next temperature one step closer to the setpoint.
- Downstream (the room model, or the bench) feeds out_temp back as the next temp, so the room converges on ideal one step per cycle.
- Also registers heating, cooling and settled status flags for display and control logic.

Parameters:
- WIDTH, 6, bit width of temp, ideal and out_temp (unsigned, 0..2^WIDTH-1).
- STEP, 1, temperature change applied per clock; legal range 1..2^WIDTH-1.
- DEADBAND, 0, no correction when |temp - ideal| <= DEADBAND; legal range 0..2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  reset, asynchronous and active-low.
- temp  input  WIDTH  current measured temperature, unsigned.
- ideal  input  WIDTH  target temperature setpoint, unsigned.
- out_temp  output  WIDTH  registered next temperature command.
- heating  output  1  registered; 1 when the last update raised temperature.
- cooling  output  1  registered; 1 when the last update lowered temperature.
- settled  output  1  registered; 1 when the last update found temp within the deadband.

Behaviour:
- Reset
  - rst_n low forces out_temp=0, heating=0, cooling=0, settled=0 immediately, without waiting for clk.
  - Outputs hold these values while rst_n is low.
  - The first update after release is on the first rising clk with rst_n high.
  - Reset asserted mid-convergence discards all progress.
- Output timing
  - All outputs are registered.
  - Latency: one clock from temp/ideal sampled at a rising edge to out_temp valid just after that edge.
  - No combinational path from inputs to outputs.
  - No handshake: inputs are sampled every cycle.
- Difference
  - diff = |temp - ideal|, computed in WIDTH+1 bits with no wrap.
  - Comparison is unsigned.
- Update at each rising edge, when rst_n is high:
  - diff <= DEADBAND: out_temp=temp; settled=1, heating=0, cooling=0.
  - temp < ideal, outside deadband: out_temp = temp+STEP if diff > STEP, else ideal (never overshoot); heating=1, cooling=0, settled=0.
  - temp > ideal, outside deadband: out_temp = temp-STEP if diff > STEP, else ideal; cooling=1, heating=0, settled=0.
  - heating and cooling are never both 1; exactly one of heating/cooling/settled is 1 after any post-reset update.
- Range and saturation
  - Results never wrap; arithmetic is effectively saturating at 0 and 2^WIDTH-1.
  - This is guaranteed by the no-overshoot rule, since ideal is in range.
  - temp=63, ideal=0 gives out_temp=62.
  - temp=0, ideal=63 gives out_temp=1.
- Input changes
  - A change to ideal or temp takes effect at the next edge; no state other than the output registers.
  - Direction may reverse in a single cycle when ideal jumps across temp.
- Open-loop inputs
  - If temp is held constant (not fed back), out_temp stays constant at the single-step value every cycle.
  - This is a stateless-step controller, not an accumulator.

Test Plan:
- Reset: rst_n=0 with temp=17, ideal=27, clk toggling -> out_temp=0, all flags 0. Assert rst_n low between edges -> outputs clear immediately, not at the next edge.
- Closed-loop heating: ideal=27, temp=17, out_temp fed back to temp after each edge.
  - Edges 1/2/3 -> out_temp=18/19/20, heating=1.
  - Continue feeding back -> reaches 27 at edge 10; edge 11 -> out_temp=27, settled=1.
- Closed-loop cooling: ideal=20, temp=25, fed back -> out_temp 24, 23, 22, 21, 20, then holds 20 with settled=1; cooling=1 while descending.
- No overshoot with STEP=4: ideal=27, temp=25 -> out_temp=27 (not 29), heating=1. Also check temp=31, ideal=29 -> out_temp=29, cooling=1.
- Deadband with DEADBAND=1:
  - ideal=27, temp=28 -> out_temp=28, settled=1.
  - temp=29 -> out_temp=28, cooling=1.
- Extremes and reversal:
  - temp=63, ideal=0 -> out_temp=62.
  - temp=0, ideal=63 -> out_temp=1.
  - Switch ideal from 40 to 10 while temp=30 -> next edge out_temp=29, cooling=1, heating=0.
